// File: rtl/oqpsk_pkg.sv
// Shared types for the OQPSK bit framer: FSM states, default sync word and FIFO entry layout.
package oqpsk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSync,
    StPayload,
    StTail
  } state_e;

  localparam logic [15:0] DefaultSyncWord = 16'hF628;
  localparam int unsigned SyncBits        = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/oqpsk_byte_fifo.sv
// Synchronous first-word-fall-through FIFO of {last, byte} entries; push while full is
// accepted only when a pop happens in the same cycle.
module oqpsk_byte_fifo
  import oqpsk_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  fifo_entry_t                  wdata_i,
  input  logic                         pop_i,
  output fifo_entry_t                  rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fifo_entry_t     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/oqpsk_bit_framer.sv
// Byte-to-bit framer feeding the OQPSK modulator: preamble, sync word, payload, tail zeros,
// each bit held for SAMPLES_PER_BIT clocks.
module oqpsk_bit_framer
  import oqpsk_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = 32,
  parameter int unsigned PREAMBLE_BITS   = 16,
  parameter logic [15:0] SYNC_WORD       = DefaultSyncWord,
  parameter int unsigned TAIL_BITS       = 8,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DataIn,
  input  logic       DataLast,
  input  logic       DataValid,
  output logic       DataReady,
  output logic       BitOut,
  output logic       EN,
  output logic       Busy,
  output logic       Underrun
);

  localparam int unsigned LongPT  = (PREAMBLE_BITS > TAIL_BITS) ? PREAMBLE_BITS : TAIL_BITS;
  localparam int unsigned MaxBits = (LongPT > SyncBits) ? LongPT : SyncBits;
  localparam int unsigned IdxW    = $clog2(MaxBits);
  localparam int unsigned SmpW    = $clog2(SAMPLES_PER_BIT);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);

  state_e          state_q, state_d;
  logic [SmpW-1:0] smp_q, smp_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [15:0]     shreg_q, shreg_d;
  logic            last_q, last_d;
  logic            bit_q, bit_d;
  logic            en_q, en_d;
  logic            underrun_q, underrun_d;

  logic            push, pop, wrap, need_byte;
  fifo_entry_t     wr_entry, rd_entry;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  assign DataReady = ~fifo_full;
  assign push      = DataValid & DataReady;
  assign wr_entry  = '{last: DataLast, data: DataIn};

  oqpsk_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign wrap = (smp_q == SmpW'(SAMPLES_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    smp_d      = smp_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    bit_d      = bit_q;
    en_d       = en_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    need_byte  = 1'b0;

    if (state_q != StIdle) smp_d = wrap ? '0 : smp_q + SmpW'(1);

    unique case (state_q)
      StIdle: begin
        if (fifo_count != '0) begin
          state_d = StPreamble;
          smp_d   = '0;
          idx_d   = '0;
          bit_d   = 1'b1;
          en_d    = 1'b1;
        end
      end
      StPreamble: begin
        if (wrap) begin
          if (idx_q == IdxW'(PREAMBLE_BITS - 1)) begin
            state_d = StSync;
            idx_d   = '0;
            bit_d   = SYNC_WORD[15];
            shreg_d = {SYNC_WORD[14:0], 1'b0};
          end else begin
            idx_d = idx_q + IdxW'(1);
            bit_d = ~bit_q;
          end
        end
      end
      StSync: begin
        if (wrap) begin
          if (idx_q == IdxW'(SyncBits - 1)) begin
            need_byte = 1'b1;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            bit_d   = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      StPayload: begin
        if (wrap) begin
          if (idx_q == IdxW'(7)) begin
            if (last_q) begin
              state_d = StTail;
              idx_d   = '0;
              bit_d   = 1'b0;
            end else begin
              need_byte = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IdxW'(1);
            bit_d   = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      StTail: begin
        if (wrap) begin
          bit_d = 1'b0;
          if (idx_q == IdxW'(TAIL_BITS - 1)) begin
            state_d = StIdle;
            idx_d   = '0;
            smp_d   = '0;
            en_d    = 1'b0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Byte boundary: pop and load the MSB, or end the frame without a partial byte.
    if (need_byte) begin
      idx_d = '0;
      if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = StPayload;
        bit_d   = rd_entry.data[7];
        shreg_d = {rd_entry.data[6:0], 9'b0};
        last_d  = rd_entry.last;
      end else begin
        underrun_d = 1'b1;
        state_d    = StTail;
        bit_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      smp_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      bit_q      <= 1'b0;
      en_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      bit_q      <= bit_d;
      en_q       <= en_d;
      underrun_q <= underrun_d;
    end
  end

  assign BitOut   = bit_q;
  assign EN       = en_q;
  assign Busy     = (state_q != StIdle);
  assign Underrun = underrun_q;

endmodule

// File: tb/tb_oqpsk_bit_framer.sv
// Bench for oqpsk_bit_framer: two instances (32 and 2 samples per bit) checked against a
// frame model built from the byte list.
module tb_oqpsk_bit_framer;

  localparam int          SpbA    = 32;
  localparam int          SpbB    = 2;
  localparam int          PreRef  = 16;
  localparam int          TailRef = 8;
  localparam logic [15:0] SyncRef = 16'hF628;
  localparam int          Bound   = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, valid, last, ready, bit_o, en, busy, underrun;
  logic [7:0] din [2];

  int errors = 0;
  int checks = 0;

  logic [8:0] tx_bytes [$];
  bit         exp_bits [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    oqpsk_bit_framer #(
      .SAMPLES_PER_BIT ((g == 0) ? SpbA : SpbB)
    ) dut (
      .CLK       (clk),
      .RST       (rst[g]),
      .DataIn    (din[g]),
      .DataLast  (last[g]),
      .DataValid (valid[g]),
      .DataReady (ready[g]),
      .BitOut    (bit_o[g]),
      .EN        (en[g]),
      .Busy      (busy[g]),
      .Underrun  (underrun[g])
    );
  end

  // Expected bit sequence of one frame starting at tx_bytes[first].
  task automatic build_expected(input int first, output int next, output int exp_under);
    logic [15:0] sw;
    logic [8:0]  e;
    sw = SyncRef;
    exp_bits.delete();
    for (int p = 0; p < PreRef; p++) exp_bits.push_back((p % 2) == 0);
    for (int b = 15; b >= 0; b--) exp_bits.push_back(sw[b]);
    next      = tx_bytes.size();
    exp_under = 1;
    for (int i = first; i < tx_bytes.size(); i++) begin
      e = tx_bytes[i];
      for (int b = 7; b >= 0; b--) exp_bits.push_back(e[b]);
      if (e[8]) begin
        next      = i + 1;
        exp_under = 0;
        break;
      end
    end
    for (int t = 0; t < TailRef; t++) exp_bits.push_back(1'b0);
  endtask

  task automatic push_bytes(input int k, output int stalls);
    int w;
    logic [8:0] e;
    stalls = 0;
    foreach (tx_bytes[i]) begin
      e = tx_bytes[i];
      din[k]   = e[7:0];
      last[k]  = e[8];
      valid[k] = 1'b1;
      w = 0;
      while (ready[k] !== 1'b1 && w < Bound) begin
        stalls++;
        w++;
        @(negedge clk);
      end
      checks++;
      if (w >= Bound) begin
        errors++;
        $display("FAIL push_timeout: inst %0d byte %0d not accepted in %0d cycles", k, i, Bound);
      end
      @(negedge clk);
    end
    valid[k] = 1'b0;
    last[k]  = 1'b0;
  endtask

  task automatic capture_frame(input int k, input int spb, input string name,
                               input int exp_under, input int exp_en);
    int   w = 0, bad = 0, en_cyc = 0, und = 0;
    logic bad_bit;
    while (en[k] !== 1'b1 && w < Bound) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= Bound) begin
      errors++;
      $display("FAIL %s_start: EN not seen within %0d cycles", name, Bound);
      return;
    end
    foreach (exp_bits[i]) begin
      bad_bit = 1'b0;
      for (int c = 0; c < spb; c++) begin
        if (bit_o[k] !== exp_bits[i]) bad_bit = 1'b1;
        if (en[k] === 1'b1) en_cyc++;
        if (underrun[k] === 1'b1) und++;
        @(negedge clk);
      end
      if (bad_bit) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_bits: %0d of %0d bits wrong, required 0", name, bad, exp_bits.size());
    end
    checks++;
    if (en_cyc != exp_en) begin
      errors++;
      $display("FAIL %s_en_len: EN high %0d cycles, required %0d", name, en_cyc, exp_en);
    end
    checks++;
    if (und != exp_under) begin
      errors++;
      $display("FAIL %s_underrun: %0d pulse cycles, required %0d", name, und, exp_under);
    end
    checks++;
    if (en[k] !== 1'b0 || busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: EN=%b Busy=%b after frame, required 0 0", name, en[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({en[k], bit_o[k], busy[k], underrun[k], ready[k]} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_state: inst %0d EN,Bit,Busy,Und,Ready=%b%b%b%b%b, required 00001",
                 k, en[k], bit_o[k], busy[k], underrun[k], ready[k]);
      end
    end
  endtask

  task automatic test_single_byte();
    int nx, eu, st;
    tx_bytes = '{9'h1A5};
    build_expected(0, nx, eu);
    push_bytes(0, st);
    checks++;
    if (en[0] !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: EN=%b right after handshake edge, required 0", en[0]);
    end
    @(negedge clk);
    checks++;
    if (en[0] !== 1'b1 || bit_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL latency_one: EN=%b Bit=%b one cycle later, required 1 1", en[0], bit_o[0]);
    end
    capture_frame(0, SpbA, "single", eu, 1536);
  endtask

  task automatic test_back_to_back();
    int nx, eu, st;
    tx_bytes = '{9'h000, 9'h0FF, 9'h13C};
    build_expected(0, nx, eu);
    fork
      push_bytes(0, st);
      capture_frame(0, SpbA, "b2b", eu, exp_bits.size() * SpbA);
    join
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL b2b_ready: DataReady low for %0d cycles, required 0", st);
    end
  endtask

  task automatic test_underrun();
    int nx, eu, st;
    tx_bytes = '{{1'b0, 8'($urandom_range(0, 255))}};
    build_expected(0, nx, eu);
    push_bytes(0, st);
    capture_frame(0, SpbA, "underrun", eu, exp_bits.size() * SpbA);
  endtask

  task automatic test_fifo_full();
    int nx, eu, st;
    tx_bytes.delete();
    for (int i = 0; i < 5; i++) tx_bytes.push_back({(i == 4), 8'($urandom_range(0, 255))});
    build_expected(0, nx, eu);
    fork
      push_bytes(0, st);
      capture_frame(0, SpbA, "full", eu, exp_bits.size() * SpbA);
    join
    // Fifth byte waits from the negedge after the 4th push until the first payload pop,
    // which is (PreRef+16) bits after EN rose one cycle past the first push.
    checks++;
    if (st != (PreRef + 16) * SpbA - 2) begin
      errors++;
      $display("FAIL full_stall: 5th byte stalled %0d cycles, required %0d", st,
               (PreRef + 16) * SpbA - 2);
    end
  endtask

  task automatic test_reset_mid_sync();
    int nx, eu, st, w;
    tx_bytes = '{{1'b1, 8'($urandom_range(0, 255))}};
    push_bytes(0, st);
    w = 0;
    while (en[0] !== 1'b1 && w < Bound) begin
      @(negedge clk);
      w++;
    end
    repeat ((PreRef + 8) * SpbA) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: Busy=%b mid-sync, required 1", busy[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checks++;
    if ({en[0], bit_o[0], busy[0], ready[0]} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_state: EN,Bit,Busy,Ready=%b%b%b%b, required 0001",
               en[0], bit_o[0], busy[0], ready[0]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || en[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush: Busy=%b EN=%b after reset, required 0 0", busy[0], en[0]);
    end
    tx_bytes = '{9'h181};
    build_expected(0, nx, eu);
    push_bytes(0, st);
    capture_frame(0, SpbA, "after_abort", eu, exp_bits.size() * SpbA);
  endtask

  task automatic test_two_frames();
    int nx, eu, nx2, eu2, st;
    tx_bytes = '{{1'b0, 8'($urandom_range(0, 255))}, {1'b1, 8'($urandom_range(0, 255))},
                 {1'b1, 8'($urandom_range(0, 255))}};
    build_expected(0, nx, eu);
    fork
      push_bytes(1, st);
      begin
        capture_frame(1, SpbB, "frame_a", eu, exp_bits.size() * SpbB);
        @(negedge clk);
        checks++;
        if (en[1] !== 1'b1) begin
          errors++;
          $display("FAIL frame_gap: EN=%b two cycles after frame A, required 1", en[1]);
        end
        build_expected(nx, nx2, eu2);
        capture_frame(1, SpbB, "frame_b", eu2, exp_bits.size() * SpbB);
      end
    join
  endtask

  initial begin
    rst   = 2'b11;
    valid = 2'b00;
    last  = 2'b00;
    din[0] = 8'h00;
    din[1] = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_fifo_full();
    test_reset_mid_sync();
    test_two_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
